// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the fetch/data requesters, the unified memory and the arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [1:0]        dm_size;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [1:0]        mem_size;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_size, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_size, stall
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_size, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_size, stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: one transaction in flight, data beats fetch, response after MEM_LATENCY.
// Define ARB_STARVE_GUARD_EN to force a fetch grant after MAX_DATA_STREAK contested data grants.
module mem_port_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MEM_LATENCY     = 2,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic          clock,
  input  logic          reset,
  mem_port_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_owner, w_owner_nxt;
  logic             r_we, w_we_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_force_if;
  logic             w_pick_dm;
  logic             w_pick_if;

  generate
    if (MEM_LATENCY < 1 || MAX_DATA_STREAK < 1) begin : g_bad_cfg
      $error("mem_port_arbiter: MEM_LATENCY and MAX_DATA_STREAK must be >= 1");
    end
  endgenerate

`ifdef ARB_STARVE_GUARD_EN
  localparam int STK_W = $clog2(MAX_DATA_STREAK + 1);
  logic [STK_W-1:0] r_streak;

  assign w_force_if = bus.if_req & bus.dm_req & (r_streak == STK_W'(MAX_DATA_STREAK));

  // Counts only data grants that actually kept a waiting fetch out.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_streak <= '0;
    end else if (bus.if_gnt) begin
      r_streak <= '0;
    end else if (bus.dm_gnt && bus.if_req && (r_streak != STK_W'(MAX_DATA_STREAK))) begin
      r_streak <= r_streak + STK_W'(1);
    end
  end
`else
  assign w_force_if = 1'b0;
`endif

  assign w_pick_dm = bus.dm_req & ~w_force_if;
  assign w_pick_if = bus.if_req & ~w_pick_dm;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_we    <= w_we_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_we_nxt      = r_we;
    w_cnt_nxt     = r_cnt;
    bus.if_gnt    = 1'b0;
    bus.dm_gnt    = 1'b0;
    bus.if_rvalid = 1'b0;
    bus.dm_rvalid = 1'b0;
    bus.if_rdata  = '0;
    bus.dm_rdata  = '0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_size  = '0;
    bus.stall     = 1'b0;
    // Outputs are forced quiet for the whole reset cycle, even with requests pending.
    if (!reset) begin
      bus.stall = (r_state != RESP) & (bus.if_req | bus.dm_req | (r_state != IDLE));
      case (r_state)
        IDLE: begin
          if (w_pick_dm || w_pick_if) begin
            bus.mem_en = 1'b1;
            if (w_pick_dm) begin
              bus.dm_gnt    = 1'b1;
              bus.mem_we    = bus.dm_we;
              bus.mem_addr  = bus.dm_addr;
              bus.mem_wdata = bus.dm_wdata;
              bus.mem_size  = bus.dm_size;
            end else begin
              bus.if_gnt   = 1'b1;
              bus.mem_addr = bus.if_addr;
              bus.mem_size = 2'b10;
            end
            w_owner_nxt = w_pick_dm;
            w_we_nxt    = w_pick_dm & bus.dm_we;
            if (MEM_LATENCY == 1) begin
              w_state_nxt = RESP;
            end else begin
              w_state_nxt = WAIT;
              w_cnt_nxt   = CNT_W'(MEM_LATENCY - 1);
            end
          end
        end
        WAIT: begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
          if (r_cnt <= CNT_W'(1)) w_state_nxt = RESP;
        end
        RESP: begin
          if (r_owner) begin
            bus.dm_rvalid = 1'b1;
            bus.dm_rdata  = r_we ? '0 : bus.mem_rdata;
          end else begin
            bus.if_rvalid = 1'b1;
            bus.if_rdata  = bus.mem_rdata;
          end
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: latency-2 instance for most scenarios, latency-1 instance for back-to-back fetch.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT), .MAX_DATA_STREAK(4)) dut (
    .clock(clock), .reset(reset), .bus(a)
  );
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(1), .MAX_DATA_STREAK(4)) dut1 (
    .clock(clock), .reset(reset), .bus(b)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  function automatic logic [31:0] mem_f(input logic [31:0] ad);
    return ad ^ 32'h0100_0013;
  endfunction

  // Memory model: read data for the accepted address appears LAT cycles later.
  logic [31:0] pa0, pa1, pb0;
  always @(posedge clock) begin
    pa0 <= a.mem_addr;
    pa1 <= pa0;
    pb0 <= b.mem_addr;
  end
  assign a.mem_rdata = mem_f(pa1);
  assign b.mem_rdata = mem_f(pb0);

  typedef struct {
    bit          own;
    logic [31:0] dat;
    int          due;
  } exp_t;
  exp_t qa[$];

  // Scoreboard for the latency-2 instance: expectation queued at grant, checked at response.
  always @(negedge clock) begin
    exp_t e;
    cyc++;
    if (reset) begin
      qa.delete();
    end else begin
      if (a.dm_gnt) begin
        e.own = 1'b1; e.dat = a.dm_we ? 32'h0 : mem_f(a.dm_addr); e.due = cyc + LAT;
        qa.push_back(e);
      end
      if (a.if_gnt) begin
        e.own = 1'b0; e.dat = mem_f(a.if_addr); e.due = cyc + LAT;
        qa.push_back(e);
      end
      if (a.if_rvalid || a.dm_rvalid) begin
        n_vec++;
        if (qa.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected_rvalid: cycle %0d if_rvalid=%b dm_rvalid=%b, none pending",
                   cyc, a.if_rvalid, a.dm_rvalid);
        end else begin
          e = qa.pop_front();
          if ({a.dm_rvalid, a.if_rvalid, (a.dm_rvalid ? a.dm_rdata : a.if_rdata), cyc}
              !== {e.own, ~e.own, e.dat, e.due}) begin
            n_err++;
            $display("FAIL sb_response: got own=%b data=%h cycle=%0d, want own=%b data=%h cycle=%0d",
                     a.dm_rvalid, (a.dm_rvalid ? a.dm_rdata : a.if_rdata), cyc, e.own, e.dat, e.due);
          end
        end
      end
      if ((a.if_rvalid && a.dm_rvalid) || (a.if_gnt && a.dm_gnt)) begin
        n_vec++;
        n_err++;
        $display("FAIL exclusive: cycle %0d gnt=%b%b rvalid=%b%b", cyc, a.if_gnt, a.dm_gnt,
                 a.if_rvalid, a.dm_rvalid);
      end
    end
  end

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_reqs();
    a.if_req = 1'b0; a.if_addr = '0;
    a.dm_req = 1'b0; a.dm_we = 1'b0; a.dm_addr = '0; a.dm_wdata = '0; a.dm_size = '0;
    b.if_req = 1'b0; b.if_addr = '0;
    b.dm_req = 1'b0; b.dm_we = 1'b0; b.dm_addr = '0; b.dm_wdata = '0; b.dm_size = '0;
  endtask

  task automatic drain();
    clear_reqs();
    repeat (LAT + 2) nxt();
  endtask

  task automatic test_reset();
    a.if_req = 1'b1; a.if_addr = 32'h0100_0000;
    a.dm_req = 1'b1; a.dm_we = 1'b1; a.dm_addr = 32'h0100_0100; a.dm_wdata = 32'h1234_5678;
    a.dm_size = 2'b10;
    b.if_req = 1'b1; b.if_addr = 32'h0100_0000;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      n_vec++;
      if ({a.if_gnt, a.dm_gnt, a.if_rvalid, a.dm_rvalid, a.mem_en, a.mem_we, a.stall} !== 7'b0) begin
        n_err++;
        $display("FAIL reset_ctrl: got %b want 0000000",
                 {a.if_gnt, a.dm_gnt, a.if_rvalid, a.dm_rvalid, a.mem_en, a.mem_we, a.stall});
      end
      n_vec++;
      if ({a.mem_addr, a.mem_wdata, a.mem_size, a.if_rdata, a.dm_rdata} !== '0) begin
        n_err++;
        $display("FAIL reset_data: addr=%h wdata=%h size=%b if_rdata=%h dm_rdata=%h, want all 0",
                 a.mem_addr, a.mem_wdata, a.mem_size, a.if_rdata, a.dm_rdata);
      end
      n_vec++;
      if ({b.if_gnt, b.if_rvalid, b.mem_en, b.stall} !== 4'b0) begin
        n_err++;
        $display("FAIL reset_lat1: got %b want 0000", {b.if_gnt, b.if_rvalid, b.mem_en, b.stall});
      end
      nxt();
    end
    clear_reqs();
    reset = 1'b0;
    @(negedge clock);
    n_vec++;
    if ({a.stall, a.mem_en} !== 2'b00) begin
      n_err++;
      $display("FAIL idle_after_reset: stall/mem_en got %b want 00", {a.stall, a.mem_en});
    end
    nxt();
  endtask

  task automatic test_fetch_only();
    logic [3:0] e [4];
    e = '{4'b1101, 4'b0001, 4'b0010, 4'b1101};  // {if_gnt, mem_en, if_rvalid, stall}
    a.if_req = 1'b1; a.if_addr = 32'h0100_0000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      n_vec++;
      if ({a.if_gnt, a.mem_en, a.if_rvalid, a.stall} !== e[k]) begin
        n_err++;
        $display("FAIL fetch_seq[%0d]: got %b want %b", k,
                 {a.if_gnt, a.mem_en, a.if_rvalid, a.stall}, e[k]);
      end
      if (k == 0) begin
        n_vec++;
        if ({a.mem_addr, a.mem_size, a.mem_we, a.dm_gnt} !== {32'h0100_0000, 2'b10, 1'b0, 1'b0}) begin
          n_err++;
          $display("FAIL fetch_mem_fields: addr=%h size=%b we=%b dm_gnt=%b", a.mem_addr, a.mem_size,
                   a.mem_we, a.dm_gnt);
        end
      end
      if (k == 2) begin
        n_vec++;
        if (a.if_rdata !== 32'h0000_0013) begin
          n_err++;
          $display("FAIL fetch_rdata: got %h want 00000013", a.if_rdata);
        end
      end
      nxt();
    end
    drain();
  endtask

  task automatic test_contention();
    logic [3:0] e [4];
    e = '{4'b1001, 4'b0001, 4'b0010, 4'b0101};  // {dm_gnt, if_gnt, dm_rvalid, stall}
    a.if_req = 1'b1; a.if_addr = 32'h0100_0080;
    a.dm_req = 1'b1; a.dm_we = 1'b0; a.dm_addr = 32'h0100_0100; a.dm_size = 2'b10;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      n_vec++;
      if ({a.dm_gnt, a.if_gnt, a.dm_rvalid, a.stall} !== e[k]) begin
        n_err++;
        $display("FAIL contention_seq[%0d]: got %b want %b", k,
                 {a.dm_gnt, a.if_gnt, a.dm_rvalid, a.stall}, e[k]);
      end
      if (k == 2) begin
        n_vec++;
        if (a.dm_rdata !== 32'h0000_0113) begin
          n_err++;
          $display("FAIL contention_rdata: got %h want 00000113", a.dm_rdata);
        end
      end
      nxt();
      if (k == 0) begin
        a.dm_req = 1'b0; a.dm_addr = 32'hFFFF_FFFF;
      end
    end
    drain();
  endtask

  task automatic test_data_write();
    logic [4:0] e [3];
    e = '{5'b11100, 5'b00000, 5'b00010};  // {dm_gnt, mem_en, mem_we, dm_rvalid, if_rvalid}
    a.dm_req = 1'b1; a.dm_we = 1'b1; a.dm_addr = 32'h0100_0200; a.dm_wdata = 32'hDEAD_BEEF;
    a.dm_size = 2'b10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      n_vec++;
      if ({a.dm_gnt, a.mem_en, a.mem_we, a.dm_rvalid, a.if_rvalid} !== e[k]) begin
        n_err++;
        $display("FAIL write_seq[%0d]: got %b want %b", k,
                 {a.dm_gnt, a.mem_en, a.mem_we, a.dm_rvalid, a.if_rvalid}, e[k]);
      end
      n_vec++;
      if (k == 0) begin
        if ({a.mem_addr, a.mem_wdata, a.mem_size} !== {32'h0100_0200, 32'hDEAD_BEEF, 2'b10}) begin
          n_err++;
          $display("FAIL write_fields: addr=%h wdata=%h size=%b", a.mem_addr, a.mem_wdata, a.mem_size);
        end
      end else if (k == 1) begin
        if ({a.mem_addr, a.mem_wdata, a.mem_size} !== '0) begin
          n_err++;
          $display("FAIL write_quiet_bus: addr=%h wdata=%h size=%b want 0", a.mem_addr, a.mem_wdata,
                   a.mem_size);
        end
      end else begin
        if (a.dm_rdata !== 32'h0) begin
          n_err++;
          $display("FAIL write_rdata: got %h want 00000000", a.dm_rdata);
        end
      end
      nxt();
      if (k == 0) begin
        a.dm_req = 1'b0; a.dm_we = 1'b0; a.dm_addr = 32'h5555_5555; a.dm_wdata = 32'h0;
      end
    end
    drain();
  endtask

  task automatic test_starvation();
    int  n_g = 0;
    bit  exp_if;
    a.if_req = 1'b1; a.if_addr = 32'h0100_0400;
    a.dm_req = 1'b1; a.dm_we = 1'b0; a.dm_addr = 32'h0100_0300; a.dm_size = 2'b10;
    for (int c = 0; c < 100 && n_g < 15; c++) begin
      @(negedge clock);
      if (a.dm_gnt || a.if_gnt) begin
`ifdef ARB_STARVE_GUARD_EN
        exp_if = (n_g % 5) == 4;
`else
        exp_if = 1'b0;
`endif
        n_vec++;
        if ({a.if_gnt, a.dm_gnt} !== {exp_if, ~exp_if}) begin
          n_err++;
          $display("FAIL starve_grant[%0d]: if_gnt/dm_gnt got %b want %b", n_g,
                   {a.if_gnt, a.dm_gnt}, {exp_if, ~exp_if});
        end
        n_g++;
      end
      nxt();
    end
    n_vec++;
    if (n_g != 15) begin
      n_err++;
      $display("FAIL starve_budget: got %0d grants want 15", n_g);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    a.if_req = 1'b1; a.if_addr = 32'h0100_0040;
    @(negedge clock);
    n_vec++;
    if (a.if_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_first_gnt: got %b want 1", a.if_gnt);
    end
    nxt();
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      n_vec++;
      if ({a.if_gnt, a.dm_gnt, a.if_rvalid, a.dm_rvalid, a.mem_en, a.mem_we, a.stall, a.mem_addr,
           a.if_rdata} !== '0) begin
        n_err++;
        $display("FAIL midreset_quiet[%0d]: ctrl=%b addr=%h if_rdata=%h", k,
                 {a.if_gnt, a.dm_gnt, a.if_rvalid, a.dm_rvalid, a.mem_en, a.mem_we, a.stall},
                 a.mem_addr, a.if_rdata);
      end
      nxt();
    end
    reset = 1'b0;
    @(negedge clock);
    n_vec++;
    if (a.if_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_regrant: got %b want 1", a.if_gnt);
    end
    nxt();
    a.if_req = 1'b0;
    nxt();
    @(negedge clock);
    n_vec++;
    if ({a.if_rvalid, a.if_rdata} !== {1'b1, 32'h0000_0053}) begin
      n_err++;
      $display("FAIL midreset_resp: got rvalid=%b data=%h want 1/00000053", a.if_rvalid, a.if_rdata);
    end
    nxt();
    drain();
  endtask

  task automatic test_back_to_back_lat1();
    logic [31:0] cur;
    logic [31:0] granted;
    logic [2:0]  exp_v;
    cur = 32'h0100_0000;
    granted = '0;
    b.if_req = 1'b1; b.if_addr = cur;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      exp_v = (k % 2 == 0) ? 3'b101 : 3'b010;  // {if_gnt, if_rvalid, stall}
      n_vec++;
      if ({b.if_gnt, b.if_rvalid, b.stall} !== exp_v) begin
        n_err++;
        $display("FAIL lat1_seq[%0d]: got %b want %b", k, {b.if_gnt, b.if_rvalid, b.stall}, exp_v);
      end
      if (k % 2 == 0) begin
        granted = cur;
      end else begin
        n_vec++;
        if (b.if_rdata !== mem_f(granted)) begin
          n_err++;
          $display("FAIL lat1_rdata[%0d]: got %h want %h", k, b.if_rdata, mem_f(granted));
        end
      end
      nxt();
      if (k % 2 == 0) begin
        cur = cur + 32'd4;
        b.if_addr = cur;
      end
    end
    clear_reqs();
    repeat (3) nxt();
  endtask

  initial begin
    clear_reqs();
    reset = 1'b1;
    #1;
    test_reset();
    test_fetch_only();
    test_contention();
    test_data_write();
    test_starvation();
    test_reset_mid();
    test_back_to_back_lat1();
    n_vec++;
    if (qa.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d pending responses want 0", qa.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
